// File: rtl/mem_line_pkg.sv
// Shared types and default widths for the cache-side line memory initiator.
package mem_line_pkg;

    localparam int unsigned DefAddrW = 28;
    localparam int unsigned DefLineW = 128;

    // Memory-side FSM: idle, waiting on a line fill, waiting on a write drain.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StWrWait = 2'd2
    } state_e;

    // One cache-side line request.
    typedef struct packed {
        logic                wr;
        logic [DefAddrW-1:0] addr;
        logic [DefLineW-1:0] wdata;
    } line_req_t;

endpackage

// File: rtl/mem_wbuf.sv
// Single-entry posted write buffer with address compare for read forwarding.
module mem_wbuf
    import mem_line_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LINE_W = DefLineW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fill_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [LINE_W-1:0] fill_data_i,
    input  logic [ADDR_W-1:0] cmp_addr_i,
    output logic              wb_valid_o,
    output logic              wb_hit_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;

    // Next-state: fill only happens when empty, clear only when full.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            addr_d  = fill_addr_i;
            data_d  = fill_data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_hit_o   = valid_q && (cmp_addr_i == addr_q);
    assign wb_addr_o  = addr_q;
    assign wb_data_o  = data_q;

endmodule

// File: rtl/mem_line_master.sv
// Cache-side initiator for the slow line memory with a posted write buffer.
module mem_line_master
    import mem_line_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LINE_W = DefLineW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state_q, state_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [LINE_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              wb_valid, wb_hit;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              wr_acc, rd_acc, rd_hit, rd_miss, wb_clear;

    // Reads are held off while one is in flight, pending or still being reported.
    always_comb begin
        if (req_wr) begin
            req_ready = !wb_valid;
        end else begin
            req_ready = !rd_pend_q && (state_q != StRdWait) && !rsp_valid_q;
        end
    end

    assign wr_acc   = req_valid && req_ready && req_wr;
    assign rd_acc   = req_valid && req_ready && !req_wr;
    assign rd_hit   = rd_acc && wb_hit;
    assign rd_miss  = rd_acc && !wb_hit;
    assign wb_clear = (state_q == StWrWait) && mem_ready;

    mem_wbuf #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_wbuf (
        .clk_i       (clk),
        .rst_i       (rst),
        .fill_i      (wr_acc),
        .clear_i     (wb_clear),
        .fill_addr_i (req_addr),
        .fill_data_i (req_wdata),
        .cmp_addr_i  (req_addr),
        .wb_valid_o  (wb_valid),
        .wb_hit_o    (wb_hit),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_data)
    );

    // Next-state and registered memory/response outputs; read work beats a buffered write.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        if (rd_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = wb_data;
        end

        unique case (state_q)
            StIdle: begin
                if (rd_pend_q) begin
                    // rd_pend stays set until the fill completes.
                    state_d    = StRdWait;
                    mem_read_d = 1'b1;
                    mem_addr_d = rd_addr_q;
                end else if (rd_miss) begin
                    state_d    = StRdWait;
                    mem_read_d = 1'b1;
                    mem_addr_d = req_addr;
                end else if (wb_valid) begin
                    state_d     = StWrWait;
                    mem_write_d = 1'b1;
                    mem_addr_d  = wb_addr;
                    mem_wdata_d = wb_data;
                end
            end
            StRdWait: begin
                if (mem_ready) begin
                    state_d     = StIdle;
                    mem_read_d  = 1'b0;
                    rd_pend_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_rdata;
                end
            end
            StWrWait: begin
                // A miss arriving during a drain waits for the next idle cycle.
                if (rd_miss) begin
                    rd_pend_d = 1'b1;
                    rd_addr_d = req_addr;
                end
                if (mem_ready) begin
                    state_d     = StIdle;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset drops the memory request lines without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with a fixed 4-cycle-latency memory model.
module tb_mem_line_master;
    import mem_line_pkg::*;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D11 = {16{8'h11}};
    localparam logic [127:0] D22 = {16{8'h22}};
    localparam logic [127:0] D44 = {16{8'h44}};
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] D66 = {16{8'h66}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_wr = 1'b0;
    logic [27:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic         req_ready, rsp_valid, mem_read, mem_write;
    logic [127:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [27:0]  mem_addr;
    logic         mem_ready;

    logic [127:0] mem_q [16];
    int           lat_cnt;
    int           checks = 0;
    int           failures = 0;
    int           both_cnt = 0;
    int           rd30_cnt = 0;

    mem_line_master u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory: ready pulses after the request line has been high for 4 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem_q[i] = '0;
            mem_q[1] = DA5;
            mem_q[5] = D55;
            lat_cnt   <= 0;
            mem_ready <= 1'b0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
            if (mem_write) mem_q[mem_addr[7:4]] = mem_wdata;
        end else if (mem_read || mem_write) begin
            if (lat_cnt == 2) mem_ready <= 1'b1;
            else lat_cnt <= lat_cnt + 1;
        end
    end

    assign mem_rdata = mem_q[mem_addr[7:4]];

    always @(negedge clk) begin
        if (mem_read && mem_write) both_cnt++;
        if (mem_read && mem_addr == 28'h0000030) rd30_cnt++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted; waited = negedges spent with ready low.
    task automatic issue(input line_req_t r, output int waited);
        req_valid = 1'b1;
        req_wr    = r.wr;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        waited    = 0;
        #1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (req_ready) @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count negedges with mem_read high until a response pulse is seen.
    task automatic wait_rsp(output int hi, output logic seen);
        hi   = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (mem_read) hi++;
        end
    endtask

    // Count negedges with mem_write high until it drops again.
    task automatic drain_watch(output int hi, output logic [27:0] addr_seen);
        hi        = 0;
        addr_seen = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_write) begin
                hi++;
                addr_seen = mem_addr;
            end else if (hi > 0) begin
                break;
            end
        end
    endtask

    initial begin
        int          w, hi;
        logic        seen;
        logic [27:0] a;
        int          rsp_cnt, rd_cnt;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Read miss
        issue('{wr: 1'b0, addr: 28'h10, wdata: '0}, w);
        check_eq("rd_ready", w, 0);
        check_eq("rd_mem_read", mem_read, 1);
        check_eq("rd_mem_addr", mem_addr, 28'h10);
        wait_rsp(hi, seen);
        check_eq("rd_hi_cycles", hi, 4);
        check_eq("rd_rsp_seen", seen, 1);
        check_eq("rd_rdata", rsp_rdata, DA5);
        @(negedge clk);
        check_eq("rd_rsp_pulse", rsp_valid, 0);

        // Posted write
        issue('{wr: 1'b1, addr: 28'h20, wdata: D11}, w);
        check_eq("wr_ready", w, 0);
        drain_watch(hi, a);
        check_eq("wr_hi_cycles", hi, 4);
        check_eq("wr_addr", a, 28'h20);
        check_eq("wr_mem_line", mem_q[2], D11);

        // Forwarding from the buffer
        issue('{wr: 1'b0, addr: 28'h10, wdata: '0}, w);
        issue('{wr: 1'b1, addr: 28'h30, wdata: D22}, w);
        check_eq("fwd_wr_ready", w, 0);
        issue('{wr: 1'b0, addr: 28'h30, wdata: '0}, w);
        check_eq("fwd_wait", w, 5);
        check_eq("fwd_rsp_valid", rsp_valid, 1);
        check_eq("fwd_rdata", rsp_rdata, D22);
        drain_watch(hi, a);
        check_eq("fwd_drain_hi", hi, 3);
        check_eq("fwd_mem_line", mem_q[3], D22);

        // Read priority over a buffered write
        issue('{wr: 1'b1, addr: 28'h40, wdata: D44}, w);
        issue('{wr: 1'b0, addr: 28'h50, wdata: '0}, w);
        check_eq("prio_rd_ready", w, 0);
        check_eq("prio_mem_read", mem_read, 1);
        check_eq("prio_mem_addr", mem_addr, 28'h50);
        check_eq("prio_no_write", mem_write, 0);
        wait_rsp(hi, seen);
        check_eq("prio_rd_hi", hi, 4);
        check_eq("prio_rsp_seen", seen, 1);
        check_eq("prio_rdata", rsp_rdata, D55);
        check_eq("prio_gap_write", mem_write, 0);
        check_eq("prio_gap_read", mem_read, 0);
        @(negedge clk);
        check_eq("prio_wr_start", mem_write, 1);
        check_eq("prio_wr_addr", mem_addr, 28'h40);

        // Back-pressure on a second write
        issue('{wr: 1'b1, addr: 28'h60, wdata: D66}, w);
        check_eq("bp_wait", w, 4);
        check_eq("bp_mem_line", mem_q[4], D44);

        // Read miss during a drain is held pending, then issued
        @(negedge clk);
        @(negedge clk);
        check_eq("pend_wr_active", mem_write, 1);
        check_eq("pend_wr_addr", mem_addr, 28'h60);
        issue('{wr: 1'b0, addr: 28'h10, wdata: '0}, w);
        check_eq("pend_rd_ready", w, 0);
        wait_rsp(hi, seen);
        check_eq("pend_rd_hi", hi, 4);
        check_eq("pend_rsp_seen", seen, 1);
        check_eq("pend_rdata", rsp_rdata, DA5);
        check_eq("pend_mem_line", mem_q[6], D66);

        // Reset mid-read
        @(negedge clk);
        issue('{wr: 1'b0, addr: 28'h20, wdata: '0}, w);
        check_eq("rr_mem_read", mem_read, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rr_async_read", mem_read, 0);
        check_eq("rr_async_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        rd_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
            if (mem_read) rd_cnt++;
        end
        check_eq("rr_no_rsp", rsp_cnt, 0);
        check_eq("rr_no_read", rd_cnt, 0);

        check_eq("excl_rd_wr", both_cnt, 0);
        check_eq("fwd_no_mem_read", rd30_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
